// File: rtl/uaz8_pkg.sv
// uaz8_pkg: shared definitions for the MicroUAZ8-20 control sequencer.
//   - instruction field positions (20-bit instruction word)
//   - opcode constants and ALU operation codes
//   - CJ codes driven to the PC/jump unit
//   - write-back select codes, sequencer states, instruction classes
package uaz8_pkg;

    // Instruction field positions
    localparam int OPC_HI = 19;
    localparam int OPC_LO = 15;
    localparam int ALU_HI = 17;
    localparam int ALU_LO = 15;
    localparam int RD_HI  = 14;
    localparam int RD_LO  = 12;
    localparam int RS_HI  = 11;
    localparam int RS_LO  = 9;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Opcodes (IR[19:15])
    localparam logic [4:0] OPC_NOP  = 5'b00000;
    localparam logic [4:0] OPC_MOV  = 5'b00001;
    localparam logic [4:0] OPC_LDI  = 5'b00010;
    localparam logic [4:0] OPC_LD   = 5'b00011;
    localparam logic [4:0] OPC_ST   = 5'b00100;
    localparam logic [4:0] OPC_HALT = 5'b00101;

    // ALU operations (IR[17:15] for 01xxx opcodes)
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    // CJ codes to the PC unit
    localparam logic [3:0] CJ_HOLD = 4'b0000;
    localparam logic [3:0] CJ_INC  = 4'b0001;
    localparam logic [3:0] CJ_JMP  = 4'b1000;
    localparam logic [3:0] CJ_JZ   = 4'b1010;
    localparam logic [3:0] CJ_JNZ  = 4'b1011;
    localparam logic [3:0] CJ_JC   = 4'b1100;
    localparam logic [3:0] CJ_JNC  = 4'b1101;
    localparam logic [3:0] CJ_JN   = 4'b1110;
    localparam logic [3:0] CJ_JNN  = 4'b1111;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_RS  = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;
    localparam logic [1:0] WB_MEM = 2'b11;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsNop,
        ClsMov,
        ClsLdi,
        ClsLd,
        ClsSt,
        ClsHalt,
        ClsAlu,
        ClsJmp,
        ClsIll
    } instr_class_e;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational opcode decoder.
//   i_Opcode  in  5  IR[19:15]
//   o_Class   out    instruction class
//   o_Alu_Op  out 3  ALU operation, 000 for non-ALU classes
//   o_Wb_Sel  out 2  write-back source select
//   o_Illegal out 1  undefined opcode
module instr_decode
    import uaz8_pkg::*;
(
    input  logic [4:0]   i_Opcode,
    output instr_class_e o_Class,
    output logic [2:0]   o_Alu_Op,
    output logic [1:0]   o_Wb_Sel,
    output logic         o_Illegal
);

    always_comb begin
        o_Class   = ClsIll;
        o_Alu_Op  = 3'b000;
        o_Wb_Sel  = WB_ALU;
        o_Illegal = 1'b0;
        casez (i_Opcode)
            OPC_NOP:  o_Class = ClsNop;
            OPC_MOV:  begin o_Class = ClsMov; o_Wb_Sel = WB_RS;  end
            OPC_LDI:  begin o_Class = ClsLdi; o_Wb_Sel = WB_IMM; end
            OPC_LD:   begin o_Class = ClsLd;  o_Wb_Sel = WB_MEM; end
            OPC_ST:   o_Class = ClsSt;
            OPC_HALT: o_Class = ClsHalt;
            5'b01???: begin o_Class = ClsAlu; o_Alu_Op = i_Opcode[2:0]; end
            5'b11???: o_Class = ClsJmp;
            default:  begin o_Class = ClsIll; o_Illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute sequencer for the MicroUAZ8-20 core.
//   Clk, Rst          clock, synchronous active-high reset
//   i_Instr           instruction word at current PC, latched in FETCH
//   i_Mem_Ready       data-memory completion for LD/ST
//   i_Resume          leave HALT
//   o_CJ              PC control (0000 hold, 0001 PC+1, 1xxx jump class)
//   o_IR, o_Rd_Sel, o_Rs_Sel, o_Imm, o_Alu_Op   instruction fields
//   o_Alu_En, o_Wb_Sel, o_Reg_We, o_Mem_Rd, o_Mem_We   datapath strobes
//   o_Illegal, o_Bus_Err, o_Halted               status
// All outputs are decoded from registered state and IR only.
module control_sequencer
    import uaz8_pkg::*;
#(
    parameter int unsigned IW          = 20,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [IW-1:0] i_Instr,
    input  logic          i_Mem_Ready,
    input  logic          i_Resume,
    output logic [3:0]    o_CJ,
    output logic [IW-1:0] o_IR,
    output logic [2:0]    o_Rd_Sel,
    output logic [2:0]    o_Rs_Sel,
    output logic [7:0]    o_Imm,
    output logic [2:0]    o_Alu_Op,
    output logic          o_Alu_En,
    output logic [1:0]    o_Wb_Sel,
    output logic          o_Reg_We,
    output logic          o_Mem_Rd,
    output logic          o_Mem_We,
    output logic          o_Illegal,
    output logic          o_Bus_Err,
    output logic          o_Halted
);

    // Counter only needs to reach MEM_TIMEOUT-1: the last waiting cycle decides the abort.
    localparam int unsigned CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit          TO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(MEM_TIMEOUT - 1) : '0;

    state_e        r_state, w_state_d;
    logic [IW-1:0] r_ir;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic          r_bus_err, w_bus_err_d;

    instr_class_e  w_class;
    logic          w_illegal;

    instr_decode u_decode (
        .i_Opcode  (r_ir[OPC_HI:OPC_LO]),
        .o_Class   (w_class),
        .o_Alu_Op  (o_Alu_Op),
        .o_Wb_Sel  (o_Wb_Sel),
        .o_Illegal (w_illegal)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) r_state <= StFetch;
        else     r_state <= w_state_d;
    end

    // IR, MEM wait counter and registered bus-error pulse
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ir      <= '0;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == StFetch) r_ir <= i_Instr;
            r_cnt     <= w_cnt_d;
            r_bus_err <= w_bus_err_d;
        end
    end

    // Next state
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = '0;
        w_bus_err_d = 1'b0;
        unique case (r_state)
            StFetch:  w_state_d = StDecode;
            StDecode: begin
                if (w_class == ClsLd || w_class == ClsSt) w_state_d = StMem;
                else if (w_class == ClsHalt)              w_state_d = StHalt;
                else                                      w_state_d = StExecute;
            end
            StExecute: begin
                if (w_class == ClsAlu || w_class == ClsMov || w_class == ClsLdi) begin
                    w_state_d = StWb;
                end else begin
                    w_state_d = StFetch;
                end
            end
            StMem: begin
                // Ready takes priority over a simultaneous timeout.
                if (i_Mem_Ready) begin
                    w_state_d = (w_class == ClsLd) ? StWb : StFetch;
                end else if (TO_EN && r_cnt == CNT_LAST) begin
                    w_state_d   = StFetch;
                    w_bus_err_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            StWb:    w_state_d = StFetch;
            StHalt:  if (i_Resume) w_state_d = StFetch;
            default: w_state_d = StFetch;
        endcase
    end

    // Outputs
    always_comb begin
        o_CJ      = CJ_HOLD;
        o_Alu_En  = 1'b0;
        o_Reg_We  = 1'b0;
        o_Mem_Rd  = 1'b0;
        o_Mem_We  = 1'b0;
        o_Illegal = 1'b0;
        o_Halted  = 1'b0;
        unique case (r_state)
            StFetch: ;
            StDecode: begin
                // Jumps defer all PC movement to EXECUTE so the PC moves once.
                o_CJ      = (w_class == ClsJmp) ? CJ_HOLD : CJ_INC;
                o_Illegal = w_illegal;
            end
            StExecute: begin
                if (w_class == ClsJmp) o_CJ = {1'b1, r_ir[ALU_HI:ALU_LO]};
                o_Alu_En = (w_class == ClsAlu);
            end
            StMem: begin
                o_Mem_Rd = (w_class == ClsLd);
                o_Mem_We = (w_class == ClsSt);
            end
            StWb:    o_Reg_We = 1'b1;
            StHalt:  o_Halted = 1'b1;
            default: ;
        endcase
    end

    assign o_IR      = r_ir;
    assign o_Rd_Sel  = r_ir[RD_HI:RD_LO];
    assign o_Rs_Sel  = r_ir[RS_HI:RS_LO];
    assign o_Imm     = r_ir[IMM_HI:IMM_LO];
    assign o_Bus_Err = r_bus_err;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point.
module tb_control_sequencer;
    import uaz8_pkg::*;

    logic        Clk, Rst;
    logic [19:0] i_Instr;
    logic        i_Mem_Ready, i_Resume;
    logic [3:0]  o_CJ;
    logic [19:0] o_IR;
    logic [2:0]  o_Rd_Sel, o_Rs_Sel, o_Alu_Op;
    logic [7:0]  o_Imm;
    logic        o_Alu_En, o_Reg_We, o_Mem_Rd, o_Mem_We;
    logic [1:0]  o_Wb_Sel;
    logic        o_Illegal, o_Bus_Err, o_Halted;

    int n_tests = 0;
    int n_fail  = 0;

    control_sequencer #(.IW(20), .MEM_TIMEOUT(15)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_Instr     (i_Instr),
        .i_Mem_Ready (i_Mem_Ready),
        .i_Resume    (i_Resume),
        .o_CJ        (o_CJ),
        .o_IR        (o_IR),
        .o_Rd_Sel    (o_Rd_Sel),
        .o_Rs_Sel    (o_Rs_Sel),
        .o_Imm       (o_Imm),
        .o_Alu_Op    (o_Alu_Op),
        .o_Alu_En    (o_Alu_En),
        .o_Wb_Sel    (o_Wb_Sel),
        .o_Reg_We    (o_Reg_We),
        .o_Mem_Rd    (o_Mem_Rd),
        .o_Mem_We    (o_Mem_We),
        .o_Illegal   (o_Illegal),
        .o_Bus_Err   (o_Bus_Err),
        .o_Halted    (o_Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [19:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, 1'b0, imm};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Every test starts and ends at a FETCH cycle.
    task automatic test_reset();
        Rst = 1'b1; i_Instr = '0; i_Mem_Ready = 1'b0; i_Resume = 1'b0;
        step(); step();
        n_tests++; if (o_IR !== 20'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 00000", o_IR); end
        n_tests++; if (o_CJ !== 4'b0000) begin n_fail++; $display("FAIL reset_cj: got %b want 0000", o_CJ); end
        n_tests++; if ({o_Reg_We, o_Mem_Rd, o_Mem_We, o_Alu_En, o_Illegal, o_Bus_Err, o_Halted} !== 7'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0000000",
                {o_Reg_We, o_Mem_Rd, o_Mem_We, o_Alu_En, o_Illegal, o_Bus_Err, o_Halted});
        end
        Rst = 1'b0;
    endtask

    task automatic test_ldi();
        logic [19:0] ins;
        ins = enc(OPC_LDI, 3'd2, 3'd0, 8'h5A);
        i_Instr = ins;
        n_tests++; if (o_CJ !== 4'b0000) begin n_fail++; $display("FAIL ldi_fetch_cj: got %b want 0000", o_CJ); end
        step();
        n_tests++; if (o_CJ !== 4'b0001) begin n_fail++; $display("FAIL ldi_decode_cj: got %b want 0001", o_CJ); end
        n_tests++; if (o_IR !== ins) begin n_fail++; $display("FAIL ldi_ir: got %h want %h", o_IR, ins); end
        step();
        n_tests++; if (o_CJ !== 4'b0000 || o_Reg_We !== 1'b0 || o_Alu_En !== 1'b0) begin
            n_fail++; $display("FAIL ldi_exec: got cj=%b we=%b aluen=%b want 0000 0 0", o_CJ, o_Reg_We, o_Alu_En);
        end
        step();
        n_tests++; if ({o_Reg_We, o_Wb_Sel, o_Rd_Sel, o_Imm} !== {1'b1, 2'b10, 3'd2, 8'h5A}) begin
            n_fail++; $display("FAIL ldi_wb: got we=%b sel=%b rd=%0d imm=%h want 1 10 2 5a",
                o_Reg_We, o_Wb_Sel, o_Rd_Sel, o_Imm);
        end
        step();
        n_tests++; if (o_Reg_We !== 1'b0) begin n_fail++; $display("FAIL ldi_we_once: got %b want 0", o_Reg_We); end
    endtask

    task automatic test_jz();
        logic [19:0] ins;
        logic        saw_inc;
        ins = enc(5'b11010, 3'd0, 3'd3, 8'h00);
        i_Instr = ins;
        saw_inc = (o_CJ === 4'b0001);
        step();
        n_tests++; if (o_CJ !== 4'b0000) begin n_fail++; $display("FAIL jz_decode_cj: got %b want 0000", o_CJ); end
        step();
        n_tests++; if (o_CJ !== CJ_JZ || o_Rs_Sel !== 3'd3) begin
            n_fail++; $display("FAIL jz_exec: got cj=%b rs=%0d want 1010 3", o_CJ, o_Rs_Sel);
        end
        step();
        saw_inc = saw_inc | (o_CJ === 4'b0001);
        n_tests++; if (saw_inc !== 1'b0) begin n_fail++; $display("FAIL jz_no_inc: got %b want 0", saw_inc); end
        n_tests++; if (o_Reg_We !== 1'b0) begin n_fail++; $display("FAIL jz_no_wb: got %b want 0", o_Reg_We); end
    endtask

    task automatic test_ld_wait();
        int rd_cycles;
        i_Instr = enc(OPC_LD, 3'd1, 3'd4, 8'h00);
        rd_cycles = 0;
        step();
        n_tests++; if (o_CJ !== 4'b0001 || o_Mem_Rd !== 1'b0) begin
            n_fail++; $display("FAIL ld_decode: got cj=%b rd=%b want 0001 0", o_CJ, o_Mem_Rd);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            if (o_Mem_Rd === 1'b1) rd_cycles++;
            if (k == 3) i_Mem_Ready = 1'b1;
            step();
        end
        i_Mem_Ready = 1'b0;
        n_tests++; if (rd_cycles != 4) begin n_fail++; $display("FAIL ld_rd_cycles: got %0d want 4", rd_cycles); end
        n_tests++; if ({o_Mem_Rd, o_Reg_We, o_Wb_Sel, o_Rd_Sel} !== {1'b0, 1'b1, 2'b11, 3'd1}) begin
            n_fail++; $display("FAIL ld_wb: got rd=%b we=%b sel=%b rdsel=%0d want 0 1 11 1",
                o_Mem_Rd, o_Reg_We, o_Wb_Sel, o_Rd_Sel);
        end
        step();
    endtask

    task automatic test_alu_mov();
        i_Instr = enc({2'b01, ALU_XOR}, 3'd5, 3'd6, 8'h00);
        step(); step();
        n_tests++; if (o_Alu_En !== 1'b1 || o_Alu_Op !== 3'b100) begin
            n_fail++; $display("FAIL xor_exec: got en=%b op=%b want 1 100", o_Alu_En, o_Alu_Op);
        end
        step();
        n_tests++; if ({o_Alu_En, o_Reg_We, o_Wb_Sel, o_Rd_Sel} !== {1'b0, 1'b1, 2'b00, 3'd5}) begin
            n_fail++; $display("FAIL xor_wb: got en=%b we=%b sel=%b rd=%0d want 0 1 00 5",
                o_Alu_En, o_Reg_We, o_Wb_Sel, o_Rd_Sel);
        end
        step();
        // Back-to-back MOV straight after the ALU instruction.
        i_Instr = enc(OPC_MOV, 3'd7, 3'd2, 8'h00);
        step();
        n_tests++; if (o_CJ !== 4'b0001 || o_Alu_Op !== 3'b000) begin
            n_fail++; $display("FAIL mov_decode: got cj=%b op=%b want 0001 000", o_CJ, o_Alu_Op);
        end
        step();
        n_tests++; if (o_Alu_En !== 1'b0) begin n_fail++; $display("FAIL mov_no_alu: got %b want 0", o_Alu_En); end
        step();
        n_tests++; if ({o_Reg_We, o_Wb_Sel} !== 3'b1_01) begin
            n_fail++; $display("FAIL mov_wb: got we=%b sel=%b want 1 01", o_Reg_We, o_Wb_Sel);
        end
        step();
    endtask

    task automatic test_st_timeout();
        int we_cycles;
        int guard;
        logic any_we, any_err;
        i_Instr = enc(OPC_ST, 3'd7, 3'd2, 8'h00);
        i_Mem_Ready = 1'b0;
        we_cycles = 0; guard = 0; any_we = 1'b0; any_err = 1'b0;
        step(); step();
        while (o_Mem_We === 1'b1 && guard < 40) begin
            we_cycles++;
            any_we  = any_we | o_Reg_We;
            any_err = any_err | o_Bus_Err;
            step();
            guard++;
        end
        n_tests++; if (we_cycles != 15) begin n_fail++; $display("FAIL st_we_cycles: got %0d want 15", we_cycles); end
        n_tests++; if (any_err !== 1'b0) begin n_fail++; $display("FAIL st_early_err: got %b want 0", any_err); end
        n_tests++; if (o_Bus_Err !== 1'b1) begin n_fail++; $display("FAIL st_bus_err: got %b want 1", o_Bus_Err); end
        i_Instr = enc(OPC_NOP, 3'd0, 3'd0, 8'h00);
        step();
        n_tests++; if (o_Bus_Err !== 1'b0 || o_CJ !== 4'b0001) begin
            n_fail++; $display("FAIL st_err_pulse: got err=%b cj=%b want 0 0001", o_Bus_Err, o_CJ);
        end
        any_we = any_we | o_Reg_We;
        step();
        any_we = any_we | o_Reg_We;
        n_tests++; if (any_we !== 1'b0) begin n_fail++; $display("FAIL st_no_reg_we: got %b want 0", any_we); end
        step();
    endtask

    task automatic test_illegal_halt();
        int halt_cycles;
        i_Instr = enc(5'b10010, 3'd0, 3'd0, 8'h00);
        step();
        n_tests++; if (o_Illegal !== 1'b1 || o_CJ !== 4'b0001) begin
            n_fail++; $display("FAIL ill_decode: got ill=%b cj=%b want 1 0001", o_Illegal, o_CJ);
        end
        step();
        n_tests++; if (o_Illegal !== 1'b0 || o_CJ !== 4'b0000 || o_Reg_We !== 1'b0) begin
            n_fail++; $display("FAIL ill_exec: got ill=%b cj=%b we=%b want 0 0000 0", o_Illegal, o_CJ, o_Reg_We);
        end
        step();
        i_Instr = enc(OPC_HALT, 3'd0, 3'd0, 8'h00);
        step();
        n_tests++; if (o_CJ !== 4'b0001 || o_Halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_decode: got cj=%b halted=%b want 0001 0", o_CJ, o_Halted);
        end
        i_Instr = enc(OPC_LDI, 3'd4, 3'd0, 8'hC3);
        step();
        halt_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            if (o_Halted === 1'b1 && o_CJ === 4'b0000) halt_cycles++;
            step();
        end
        n_tests++; if (halt_cycles != 5) begin n_fail++; $display("FAIL halt_hold: got %0d want 5", halt_cycles); end
        i_Resume = 1'b1;
        step();
        i_Resume = 1'b0;
        n_tests++; if (o_Halted !== 1'b0 || o_CJ !== 4'b0000) begin
            n_fail++; $display("FAIL halt_resume: got halted=%b cj=%b want 0 0000", o_Halted, o_CJ);
        end
        step();
        n_tests++; if (o_CJ !== 4'b0001 || o_Imm !== 8'hC3) begin
            n_fail++; $display("FAIL resume_fetch: got cj=%b imm=%h want 0001 c3", o_CJ, o_Imm);
        end
        step(); step(); step();
    endtask

    task automatic test_reset_mid();
        logic [19:0] nxt;
        i_Instr = enc({2'b01, ALU_ADD}, 3'd3, 3'd1, 8'h00);
        step(); step();
        n_tests++; if (o_Alu_En !== 1'b1) begin n_fail++; $display("FAIL add_exec: got %b want 1", o_Alu_En); end
        Rst = 1'b1;
        step();
        n_tests++; if ({o_IR, o_Reg_We, o_CJ, o_Alu_En} !== {20'h0, 1'b0, 4'b0000, 1'b0}) begin
            n_fail++; $display("FAIL rst_mid_1: got ir=%h we=%b cj=%b en=%b want 00000 0 0000 0",
                o_IR, o_Reg_We, o_CJ, o_Alu_En);
        end
        step();
        Rst = 1'b0;
        nxt = enc(OPC_MOV, 3'd6, 3'd5, 8'h00);
        i_Instr = nxt;
        n_tests++; if (o_Reg_We !== 1'b0 || o_CJ !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid_2: got we=%b cj=%b want 0 0000", o_Reg_We, o_CJ);
        end
        step();
        n_tests++; if (o_IR !== nxt || o_CJ !== 4'b0001) begin
            n_fail++; $display("FAIL rst_refetch: got ir=%h cj=%b want %h 0001", o_IR, o_CJ, nxt);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_jz();
        test_ld_wait();
        test_alu_mov();
        test_st_timeout();
        test_illegal_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit MicroUAZ8-20 core. Latches the 20-bit instruction addressed by the PC unit and decodes it.
- Issues the 4-bit CJ code that drives the PC/jump unit directly downstream of it, plus register-file, ALU and data-memory strobes.
- Sole owner of the instruction cycle; the PC unit only reacts to CJ.

Parameters:
- IW, 20, instruction width in bits; fields below assume 20.
- MEM_TIMEOUT, 15, max cycles in MEM waiting for i_Mem_Ready before abort; 0 disables the timeout.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- i_Instr  in  IW  instruction word from program memory at the current PC (valid in FETCH)
- i_Mem_Ready  in  1  data-memory completion for LD/ST
- i_Resume  in  1  leave HALT state
- o_CJ  out  4  PC control: 0000 hold, 0001 PC+1, 1xxx jump class to PC unit
- o_IR  out  IW  instruction register
- o_Rd_Sel  out  3  IR[14:12]
- o_Rs_Sel  out  3  IR[11:9]; also selects the jump target register (i_Rx of PC unit)
- o_Imm  out  8  IR[7:0]
- o_Alu_Op  out  3  IR[17:15] for ALU class, else 000
- o_Alu_En  out  1  ALU result valid/flags update (EXECUTE, ALU class)
- o_Wb_Sel  out  2  00 ALU, 01 Rs, 10 Imm, 11 memory data
- o_Reg_We  out  1  register-file write strobe
- o_Mem_Rd  out  1  data-memory read request
- o_Mem_We  out  1  data-memory write request
- o_Illegal  out  1  one-cycle pulse on undefined opcode
- o_Bus_Err  out  1  one-cycle pulse on MEM timeout
- o_Halted  out  1  high while in HALT

Behaviour:
- Opcode = IR[19:15]. 00000 NOP; 00001 MOV Rd,Rs; 00010 LDI Rd,imm; 00011 LD Rd,[Rs]; 00100 ST [Rs],Rd; 00101 HALT; 01xxx ALU (op = [17:15]: ADD, SUB, AND, OR, XOR, NOT, SHL, SHR); 11xxx jump, CJ = {1,IR[17:15]}; all others are illegal.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- Reset: state=FETCH, IR=0, timeout counter=0; all strobes 0; o_CJ=0000. Reset mid-instruction abandons it; no strobe fires on the following cycle.
- FETCH: IR<=i_Instr; o_CJ=0000; next DECODE.
- DECODE: o_CJ=0001 for every non-jump, including illegal and HALT; o_CJ=0000 for jumps.
  - LD/ST -> MEM; HALT -> HALT; all others -> EXECUTE.
  - Illegal opcode: o_Illegal pulses this cycle, then treated as NOP.
- EXECUTE:
  - Jumps: o_CJ={1,IR[17:15]}. The PC unit resolves the condition itself (taken -> Rs, else PC+1).
  - ALU: o_Alu_En=1.
  - ALU/MOV/LDI -> WB; others -> FETCH.
- MEM:
  - o_Mem_Rd (LD) or o_Mem_We (ST) held high while waiting; counter increments each cycle.
  - On i_Mem_Ready: LD -> WB, ST -> FETCH, counter cleared.
  - Counter reaching MEM_TIMEOUT with no ready: o_Bus_Err pulse, request drops, -> FETCH, no register write.
  - Ready on the same cycle as timeout: ready wins.
- WB: o_Reg_We=1 for exactly one cycle, o_Wb_Sel per class; -> FETCH.
- HALT: o_Halted=1, o_CJ=0000. Stays until i_Resume, then -> FETCH at the already-incremented PC.
- Latency: NOP/jump/illegal/HALT entry = 3 cycles; ALU/MOV/LDI = 4; ST = 3+w; LD = 4+w, where w = extra wait cycles (>=0).
- o_CJ is never 0001 and 1xxx in the same instruction, so the PC advances exactly once per instruction.
- All outputs decode from registered state and IR only; no combinational input-to-output paths.

Decomposition:
- Package uaz8_pkg holds:
  - opcode constants and ALU op codes
  - CJ codes (CJ_HOLD, CJ_INC, CJ_JMP=1000, CJ_JZ=1010, CJ_JNZ=1011, CJ_JC=1100, CJ_JNC=1101, CJ_JN=1110, CJ_JNN=1111)
  - state encoding and field bit positions
- One natural sub-module: instr_decode, purely combinational. Maps IR to class, alu_op, wb_sel and illegal.

Test Plan:
- Rst high 2 cycles mid-EXECUTE of ADD -> next cycle state FETCH, IR=0, o_Reg_We=0, o_CJ=0000.
- LDI R2,0x5A -> o_CJ=0001 in cycle 2; cycle 4 o_Reg_We=1, o_Wb_Sel=10, o_Rd_Sel=2, o_Imm=5A; next FETCH in cycle 5.
- JZ (11010) with Rs=3 -> DECODE o_CJ=0000, EXECUTE o_CJ=1010, o_Rs_Sel=3; never 0001 for this instruction.
- LD R1,[R4] with i_Mem_Ready after 3 wait cycles -> o_Mem_Rd high 4 cycles, then WB with o_Wb_Sel=11; total 7 cycles.
- ST with i_Mem_Ready stuck low, MEM_TIMEOUT=15 -> o_Mem_We drops after 15 cycles, o_Bus_Err single pulse, o_Reg_We never asserted.
- Opcode 10010 -> o_Illegal one pulse in DECODE, o_CJ=0001. HALT then: o_Halted=1, o_CJ=0000 until i_Resume, then FETCH.
